// File: rtl/count_sequence_checker.sv
// count_sequence_checker: receive-side monitor for a free-running binary
// counter stream. Predicts the next value, acquires lock after a run of
// correct samples, then flags and counts skips, repeats and resets.
module count_sequence_checker #(
    parameter int WIDTH      = 6,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 sample_valid,
    input  logic [WIDTH-1:0]     sample,
    input  logic                 clear_stats,
    output logic                 locked,
    output logic                 error_pulse,
    output logic [WIDTH-1:0]     expected,
    output logic [ERR_WIDTH-1:0] error_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        HOLD    = 2'd3
    } stateT;

    localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);
    localparam logic [3:0] LossCnt = 4'(LOSS_COUNT);

    stateT                state_q, state_d;
    logic [WIDTH-1:0]     expected_q, expected_d;
    logic [3:0]           runCount_q, runCount_d;
    logic [3:0]           missCount_q, missCount_d;
    logic                 errorPulse_q, errorPulse_d;
    logic [ERR_WIDTH-1:0] errorCount_q, errorCount_d;

    logic                 isMatch;
    logic [WIDTH-1:0]     sampleNext;
    logic [WIDTH-1:0]     expectedNext;
    logic [3:0]           runNext;
    logic [3:0]           missNext;

    assign isMatch      = (sample == expected_q);
    assign sampleNext   = sample + WIDTH'(1);
    assign expectedNext = expected_q + WIDTH'(1);
    assign runNext      = runCount_q + 4'd1;
    assign missNext     = missCount_q + 4'd1;

    // Next-state logic: only a valid sample moves the tracker; idle cycles hold everything
    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        runCount_d   = runCount_q;
        missCount_d  = missCount_q;
        errorPulse_d = 1'b0;

        if (sample_valid) begin
            unique case (state_q)
                IDLE: begin
                    expected_d = sampleNext;
                    runCount_d = 4'd1;
                    state_d    = ACQUIRE;
                end
                ACQUIRE: begin
                    if (isMatch) begin
                        expected_d = expectedNext;
                        runCount_d = runNext;
                        if (runNext >= LockCnt) begin
                            state_d     = LOCKED;
                            missCount_d = 4'd0;
                        end
                    end else begin
                        expected_d = sampleNext;
                        runCount_d = 4'd1;
                    end
                end
                LOCKED: begin
                    if (isMatch) begin
                        expected_d = expectedNext;
                    end else begin
                        errorPulse_d = 1'b1;
                        if (LossCnt <= 4'd1) begin
                            expected_d  = sampleNext;
                            runCount_d  = 4'd1;
                            missCount_d = 4'd0;
                            state_d     = ACQUIRE;
                        end else begin
                            expected_d  = expectedNext;
                            missCount_d = 4'd1;
                            state_d     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (isMatch) begin
                        expected_d  = expectedNext;
                        missCount_d = 4'd0;
                        state_d     = LOCKED;
                    end else begin
                        errorPulse_d = 1'b1;
                        if (missNext >= LossCnt) begin
                            expected_d  = sampleNext;
                            runCount_d  = 4'd1;
                            missCount_d = 4'd0;
                            state_d     = ACQUIRE;
                        end else begin
                            expected_d  = expectedNext;
                            missCount_d = missNext;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Error counter: a clear wins over a same-cycle increment, and counting stops at all-ones
    always_comb begin
        errorCount_d = errorCount_q;
        if (clear_stats) begin
            errorCount_d = '0;
        end else if (errorPulse_d && (errorCount_q != {ERR_WIDTH{1'b1}})) begin
            errorCount_d = errorCount_q + ERR_WIDTH'(1);
        end
    end

    // State and output registers; reset discards all stream history
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            expected_q   <= '0;
            runCount_q   <= 4'd0;
            missCount_q  <= 4'd0;
            errorPulse_q <= 1'b0;
            errorCount_q <= '0;
        end else begin
            state_q      <= state_d;
            expected_q   <= expected_d;
            runCount_q   <= runCount_d;
            missCount_q  <= missCount_d;
            errorPulse_q <= errorPulse_d;
            errorCount_q <= errorCount_d;
        end
    end

    assign locked      = (state_q == LOCKED) || (state_q == HOLD);
    assign error_pulse = errorPulse_q;
    assign expected    = expected_q;
    assign error_count = errorCount_q;

endmodule
